// File: rtl/stl_lut_pkg.sv
// Shared types for the key/data lookup table: response status codes and request opcodes.
package stl_lut_pkg;

    typedef enum logic [2:0] {
        INS   = 3'd0,
        UPD   = 3'd1,
        EVICT = 3'd2,
        DEL   = 3'd3,
        MISS  = 3'd4,
        ERR   = 3'd5
    } status_e;

    localparam logic OP_WRITE  = 1'b0;
    localparam logic OP_DELETE = 1'b1;

endpackage

// File: rtl/stl_mux_internal.sv
// Key-addressed combinational mux over a packed {key,data} table.
// With HAS_DEFAULT set, the last entry's data is returned when no other key matches.
module stl_mux_internal #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 8,
    parameter int DATA_LEN    = 32,
    parameter int HAS_DEFAULT = 0
) (
    input  logic [KEY_LEN-1:0]                     sel_key,
    input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
    output logic [DATA_LEN-1:0]                    data
);

    localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

    logic any_hit;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        any_hit = 1'b0;
        data    = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (HAS_DEFAULT != 0 && i == NR_KEY - 1) begin
                if (!any_hit) data = lut[i*PAIR_LEN +: DATA_LEN];
            end else if (lut[i*PAIR_LEN + DATA_LEN +: KEY_LEN] == sel_key) begin
                data    = data | lut[i*PAIR_LEN +: DATA_LEN];
                any_hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stl_lut_table.sv
// Key/data table with insert/update/delete requests, round-robin eviction when full,
// a registered lookup port and a packed export of the table for downstream muxes.
module stl_lut_table
    import stl_lut_pkg::*;
#(
    parameter  int NR_KEY   = 4,
    parameter  int KEY_LEN  = 8,
    parameter  int DATA_LEN = 32,
    localparam int PAIR_LEN = KEY_LEN + DATA_LEN,
    localparam int CW       = $clog2(NR_KEY + 1),
    localparam int IW       = $clog2(NR_KEY)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_op,
    input  logic [KEY_LEN-1:0]         req_key,
    input  logic [DATA_LEN-1:0]        req_data,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output status_e                    resp_status,
    output logic [IW-1:0]              resp_idx,
    input  logic                       flush,
    input  logic [KEY_LEN-1:0]         lk_key,
    output logic                       lk_hit,
    output logic [DATA_LEN-1:0]        lk_data,
    output logic [NR_KEY*PAIR_LEN-1:0] lut,
    output logic [NR_KEY-1:0]          valid,
    output logic [CW-1:0]              count,
    output logic                       full
);

    localparam logic [KEY_LEN-1:0] RSV_KEY = '1;

    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];
    logic [IW-1:0]       rr_ptr;

    logic [NR_KEY-1:0]   req_match, lk_match;
    logic [IW-1:0]       match_idx, free_idx, nxt_idx;
    logic                req_hit, free_found, accept;
    logic                wr_en, ins_en, del_en, evict_en;
    status_e             nxt_status;
    logic [CW-1:0]       count_nxt;
    logic                lk_hit_d;
    logic [DATA_LEN-1:0] mux_data;

    assign req_ready = !flush && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    always_comb begin
        for (int i = 0; i < NR_KEY; i++) begin
            req_match[i] = valid[i] && (key_q[i] == req_key);
            lk_match[i]  = valid[i] && (key_q[i] == lk_key);
        end
    end

    // Lowest-index free entry wins: scan downward so the last assignment is the smallest index.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        match_idx  = '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (req_match[i]) match_idx = IW'(i);
        end
    end

    assign req_hit = |req_match;

    always_comb begin
        nxt_status = INS;
        nxt_idx    = '0;
        wr_en      = 1'b0;
        ins_en     = 1'b0;
        del_en     = 1'b0;
        evict_en   = 1'b0;
        if (req_key == RSV_KEY) begin
            nxt_status = ERR;
        end else if (req_op == OP_DELETE) begin
            if (req_hit) begin
                nxt_status = DEL;
                nxt_idx    = match_idx;
                del_en     = 1'b1;
            end else begin
                nxt_status = MISS;
            end
        end else if (req_hit) begin
            nxt_status = UPD;
            nxt_idx    = match_idx;
            wr_en      = 1'b1;
        end else if (free_found) begin
            nxt_status = INS;
            nxt_idx    = free_idx;
            wr_en      = 1'b1;
            ins_en     = 1'b1;
        end else begin
            nxt_status = EVICT;
            nxt_idx    = rr_ptr;
            wr_en      = 1'b1;
            evict_en   = 1'b1;
        end
    end

    assign count_nxt = count + CW'(ins_en) - CW'(del_en);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the key/data storage is reset as well, since lut exposes it and the table is tiny.
            for (int i = 0; i < NR_KEY; i++) begin
                key_q[i]  <= RSV_KEY;
                data_q[i] <= '0;
            end
            valid  <= '0;
            rr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (flush) begin
            valid  <= '0;
            rr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (accept) begin
            if (wr_en) begin
                key_q[nxt_idx]  <= req_key;
                data_q[nxt_idx] <= req_data;
                valid[nxt_idx]  <= 1'b1;
            end
            if (del_en) valid[nxt_idx] <= 1'b0;
            if (evict_en) rr_ptr <= (rr_ptr == IW'(NR_KEY - 1)) ? '0 : rr_ptr + IW'(1);
            count <= count_nxt;
            full  <= (count_nxt == CW'(NR_KEY));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_status <= INS;
            resp_idx    <= '0;
        end else if (accept) begin
            resp_valid  <= 1'b1;
            resp_status <= nxt_status;
            resp_idx    <= nxt_idx;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

    for (genvar n = 0; n < NR_KEY; n++) begin : g_lut
        assign lut[PAIR_LEN*n +: PAIR_LEN] = valid[n] ? {key_q[n], data_q[n]}
                                                      : {RSV_KEY, {DATA_LEN{1'b0}}};
    end

    stl_mux_internal #(
        .NR_KEY      (NR_KEY),
        .KEY_LEN     (KEY_LEN),
        .DATA_LEN    (DATA_LEN),
        .HAS_DEFAULT (0)
    ) u_lk_mux (
        .sel_key (lk_key),
        .lut     (lut),
        .data    (mux_data)
    );

    assign lk_hit_d = (lk_key != RSV_KEY) && |lk_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk_hit  <= 1'b0;
            lk_data <= '0;
        end else begin
            lk_hit  <= lk_hit_d;
            lk_data <= lk_hit_d ? mux_data : '0;
        end
    end

endmodule

// File: tb/tb_stl_lut_table.sv
// Directed and randomized bench for stl_lut_table against a rule-level table model.
module tb_stl_lut_table;
    import stl_lut_pkg::*;

    localparam int N  = 4;
    localparam int KL = 8;
    localparam int DL = 32;
    localparam int PL = KL + DL;

    logic            clk, rst_n;
    logic            req_valid, req_ready, req_op;
    logic [KL-1:0]   req_key;
    logic [DL-1:0]   req_data;
    logic            resp_valid, resp_ready;
    status_e         resp_status;
    logic [1:0]      resp_idx;
    logic            flush;
    logic [KL-1:0]   lk_key;
    logic            lk_hit;
    logic [DL-1:0]   lk_data;
    logic [N*PL-1:0] lut;
    logic [N-1:0]    valid;
    logic [2:0]      count;
    logic            full;

    stl_lut_table #(.NR_KEY(N), .KEY_LEN(KL), .DATA_LEN(DL)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_key(req_key), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_status(resp_status), .resp_idx(resp_idx),
        .flush(flush), .lk_key(lk_key), .lk_hit(lk_hit), .lk_data(lk_data),
        .lut(lut), .valid(valid), .count(count), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: the table as plain arrays plus the response channel state.
    logic [KL-1:0] m_key [N];
    logic [DL-1:0] m_data [N];
    logic [N-1:0]  m_valid;
    int            m_rr;
    logic          m_rv;
    status_e       m_st;
    int            m_idx;
    logic          m_lk_hit;
    logic [DL-1:0] m_lk_data;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid   = '0;
        m_rr      = 0;
        m_rv      = 1'b0;
        m_st      = INS;
        m_idx     = 0;
        m_lk_hit  = 1'b0;
        m_lk_data = '0;
        for (int i = 0; i < N; i++) begin
            m_key[i]  = '1;
            m_data[i] = '0;
        end
    endtask

    task automatic model_req(input logic op, input logic [KL-1:0] k, input logic [DL-1:0] d,
                             output status_e st, output int idx);
        int found;
        found = -1;
        st    = MISS;
        idx   = 0;
        for (int i = 0; i < N; i++)
            if (m_valid[i] && m_key[i] == k) found = i;
        if (k == 8'hFF) begin
            st = ERR;
        end else if (op == OP_DELETE) begin
            if (found >= 0) begin
                m_valid[found] = 1'b0;
                st  = DEL;
                idx = found;
            end
        end else if (found >= 0) begin
            m_data[found] = d;
            st  = UPD;
            idx = found;
        end else if ($countones(m_valid) < N) begin
            idx = 0;
            while (m_valid[idx]) idx++;
            st = INS;
            m_key[idx] = k; m_data[idx] = d; m_valid[idx] = 1'b1;
        end else begin
            idx = m_rr;
            st  = EVICT;
            m_key[idx] = k; m_data[idx] = d;
            m_rr = (m_rr + 1) % N;
        end
    endtask

    function automatic logic [N*PL-1:0] model_lut();
        logic [N*PL-1:0] v;
        for (int i = 0; i < N; i++)
            v[i*PL +: PL] = m_valid[i] ? {m_key[i], m_data[i]} : {8'hFF, 32'h0};
        return v;
    endfunction

    task automatic check_all();
        check("resp_valid", resp_valid, m_rv);
        if (m_rv) begin
            check("resp_status", resp_status, m_st);
            check("resp_idx", resp_idx, m_idx);
        end
        check("lk_hit", lk_hit, m_lk_hit);
        check("lk_data", lk_data, m_lk_data);
        check("valid", valid, m_valid);
        check("count", count, $countones(m_valid));
        check("full", full, $countones(m_valid) == N);
        check("lut", lut, model_lut());
    endtask

    // One clock: entered 1 time unit after an edge with inputs already driven.
    task automatic step();
        logic exp_rdy, acc, op, hit, fl, rr;
        logic [KL-1:0] k;
        logic [DL-1:0] d, dat;
        status_e st;
        int idx;
        #1;
        exp_rdy = !flush && (!m_rv || resp_ready);
        check("req_ready", req_ready, exp_rdy);
        acc = req_valid && exp_rdy;
        op = req_op; k = req_key; d = req_data; fl = flush; rr = resp_ready;
        hit = 1'b0; dat = '0;
        if (lk_key != 8'hFF)
            for (int i = 0; i < N; i++)
                if (m_valid[i] && m_key[i] == lk_key) begin hit = 1'b1; dat = m_data[i]; end
        @(posedge clk); #1;
        m_lk_hit = hit; m_lk_data = dat;
        if (acc) begin
            model_req(op, k, d, st, idx);
            m_rv = 1'b1; m_st = st; m_idx = idx;
        end else if (rr) begin
            m_rv = 1'b0;
        end
        if (fl) begin m_valid = '0; m_rr = 0; end
        check_all();
    endtask

    task automatic req(input logic op, input logic [KL-1:0] k, input logic [DL-1:0] d);
        req_valid = 1'b1; req_op = op; req_key = k; req_data = d;
        step();
        req_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input status_e st, input int idx);
        check({tag, "_status"}, resp_status, st);
        check({tag, "_idx"}, resp_idx, idx);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_key = '0; req_data = '0;
        resp_ready = 1'b1; flush = 1'b0; lk_key = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_all();
        check("rst_status", resp_status, INS);
        check("rst_lut", lut, {N{8'hFF, 32'h0}});

        lk_key = 8'h05;
        step();
        check("lk_empty_hit", lk_hit, 1'b0);

        req(OP_WRITE, 8'h05, 32'hDEADBEEF);
        expect_resp("ins5", INS, 0);
        check("ins5_count", count, 3'd1);
        step();
        check("lk5_hit", lk_hit, 1'b1);
        check("lk5_data", lk_data, 32'hDEADBEEF);
        req(OP_WRITE, 8'h05, 32'h1);
        expect_resp("upd5", UPD, 0);
        check("upd5_count", count, 3'd1);
        req(OP_DELETE, 8'h05, 32'h0);
        expect_resp("del5", DEL, 0);

        for (int i = 1; i <= 4; i++) begin
            req(OP_WRITE, KL'(i), 32'h100 + DL'(i));
            expect_resp("fill", INS, i - 1);
        end
        check("fill_full", full, 1'b1);
        req(OP_WRITE, 8'h09, 32'h9);
        expect_resp("evict9", EVICT, 0);
        req(OP_WRITE, 8'h0A, 32'hA);
        expect_resp("evict10", EVICT, 1);
        lk_key = 8'h01;
        step();
        check("lk1_evicted", lk_hit, 1'b0);

        req(OP_DELETE, 8'h0A, 32'h0);
        expect_resp("del10", DEL, 1);
        check("del10_key", lut[PL + DL +: KL], 8'hFF);
        req(OP_DELETE, 8'h0A, 32'h0);
        expect_resp("del10_again", MISS, 0);
        req(OP_WRITE, 8'hFF, 32'h55);
        expect_resp("rsv", ERR, 0);
        check("rsv_count", count, 3'd3);
        req(OP_WRITE, 8'h02, 32'h22);
        expect_resp("reuse", INS, 1);

        // Backpressure: drain, then hold the response and keep a request pending.
        step();
        resp_ready = 1'b0;
        req_valid = 1'b1; req_op = OP_WRITE; req_key = 8'h06; req_data = 32'h66;
        step();
        repeat (2) begin
            step();
            check("bp_stall", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        for (int i = 7; i <= 9; i++) begin
            req_key = KL'(i); req_data = DL'(i);
            step();
        end
        req_valid = 1'b0;
        step();

        // Flush together with a request: nothing accepted, round-robin pointer restarts.
        req_valid = 1'b1; req_key = 8'h30; flush = 1'b1;
        step();
        flush = 1'b0; req_valid = 1'b0;
        check("flush_count", count, 3'd0);
        for (int i = 0; i < 5; i++) req(OP_WRITE, 8'h40 + KL'(i), DL'(i));
        expect_resp("flush_rr", EVICT, 0);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            req_op     = ($urandom_range(0, 3) == 0);
            req_key    = ($urandom_range(0, 9) == 0) ? 8'hFF : KL'($urandom_range(0, 7));
            req_data   = $urandom;
            resp_ready = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            lk_key     = ($urandom_range(0, 9) == 0) ? 8'hFF : KL'($urandom_range(0, 7));
            step();
        end
        flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        step();

        // Asynchronous reset while a response is pending.
        resp_ready = 1'b0;
        req(OP_WRITE, 8'h11, 32'h1111);
        check("pre_rst_rv", resp_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rv", resp_valid, 1'b0);
        check("async_rst_count", count, 3'd0);
        check("async_rst_lut", lut, {N{8'hFF, 32'h0}});
        model_reset();
        #2 rst_n = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req(OP_WRITE, 8'h12, 32'h1212);
        expect_resp("post_rst", INS, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
